// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding for the FIFO write-port arbiter
package fifo_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at or above ptr, modulo N
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic          any
);
   logic [PW-1:0] j;
   always_comb begin
      pick = '0;
      j    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = PW'((int'(ptr) + k) % N);
         pick = req[j] ? N'(1) << j : pick;
      end
   end
   assign any = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked sharing of one FIFO write port among N streams
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int DW       = 16,
   parameter int MAXBURST = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_valid,
   input  logic [N*DW-1:0] req_data,
   input  logic [N-1:0]    req_last,
   output logic [N-1:0]    req_ready,
   input  logic            fifo_full,
   output logic            fifo_wr_en,
   output logic [DW-1:0]   fifo_wr_data,
   output logic [N-1:0]    grant,
   output logic            busy
);
   localparam int PW = $clog2(N);
   localparam int CW = MAXBURST > 1 ? $clog2(MAXBURST + 1) : 1;
   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d, pick;
   logic [PW-1:0] rr_q, rr_d, g, nxt;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          any, done;
   always_comb begin
      g            = '0;
      fifo_wr_data = '0;
      for (int i = 0; i < N; i++) begin
         g            = grant_q[i] ? PW'(i) : g;
         fifo_wr_data = grant_q[i] ? req_data[i*DW +: DW] : fifo_wr_data;
      end
   end
   assign grant      = grant_q;
   assign busy       = state_q == BURST;
   assign req_ready  = grant_q & {N{~fifo_full}};
   assign fifo_wr_en = |(grant_q & req_valid) & ~fifo_full;
   assign done       = fifo_wr_en & (|(grant_q & req_last) | (MAXBURST != 0 && cnt_q == CW'(MAXBURST - 1)));
   assign nxt        = (g == PW'(N - 1)) ? '0 : g + 1'b1;
   // the owner is masked out so a finishing requester cannot immediately re-win
   rr_pick #(.N(N)) u_pick (
      .req (req_valid & ~grant_q),
      .ptr (busy ? nxt : rr_q),
      .pick(pick),
      .any (any)
   );
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      if (!busy) begin
         state_d = any ? BURST : IDLE;
         grant_d = pick;
      end else if (fifo_wr_en) begin
         cnt_d   = done ? '0 : cnt_q + 1'b1;
         rr_d    = done ? nxt : rr_q;
         grant_d = done ? pick : grant_q;
         state_d = (done && !any) ? IDLE : BURST;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table vectors, directed corner sequences and random traffic against a
// requester-level model, on an unlimited-burst instance (u0) and a MAXBURST=2 instance (u1)
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        rst, fifo_full;
   logic [3:0]  vld, lst, acc;
   logic [15:0] dat [4];
   logic [63:0] rdata;
   logic [3:0]  rdy0, rdy1, g0, g1;
   logic        wr0, wr1, b0, b1;
   logic [15:0] wd0, wd1;
   typedef struct packed {
      logic [3:0] v, l; logic f; logic [3:0] g; logic w; logic [15:0] d; logic [3:0] r; logic b;
   } vec_t;
   vec_t        tbl [11];
   logic [16:0] mem [4][256];
   int          wp [4], rp [4], sq [4];
   int          own [2], rr [2], cnt [2];
   int          checks, errors, cyc, ln, sel;
   logic        rnd, man;
   logic [15:0] ld [256];
   int          lc [256];
   int          e2 [5];
   logic [15:0] e4 [6];

   assign rdata = {dat[3], dat[2], dat[1], dat[0]};
   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(4), .DW(16), .MAXBURST(0)) u0 (
      .clk(clk), .rst(rst), .req_valid(vld), .req_data(rdata), .req_last(lst), .req_ready(rdy0),
      .fifo_full(fifo_full), .fifo_wr_en(wr0), .fifo_wr_data(wd0), .grant(g0), .busy(b0));
   fifo_wr_arbiter #(.N(4), .DW(16), .MAXBURST(2)) u1 (
      .clk(clk), .rst(rst), .req_valid(vld), .req_data(rdata), .req_last(lst), .req_ready(rdy1),
      .fifo_full(fifo_full), .fifo_wr_en(wr1), .fifo_wr_data(wd1), .grant(g1), .busy(b1));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
      end
   endtask

   function automatic int find(int s, int ex);
      for (int j = 0; j < 4; j++) begin
         int x;
         x = (s + j) % 4;
         if (vld[x] && x != ex) return x;
      end
      return -1;
   endfunction

   // owner-level model: who holds the port, whose turn is next, beats taken in this grant
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int o;
         logic eb, ew;
         logic [3:0] eg, er;
         logic [15:0] ed;
         o  = own[k];
         eb = o >= 0;
         eg = eb ? 4'(1 << o) : 4'b0;
         ew = eb ? (vld[o[1:0]] && !fifo_full) : 1'b0;
         ed = eb ? dat[o[1:0]] : 16'h0;
         er = (eb && !fifo_full) ? eg : 4'b0;
         chk($sformatf("u%0d_grant", k), k ? g1 : g0, eg);
         chk($sformatf("u%0d_busy", k), k ? b1 : b0, eb);
         chk($sformatf("u%0d_wr_en", k), k ? wr1 : wr0, ew);
         chk($sformatf("u%0d_wr_data", k), k ? wd1 : wd0, ed);
         chk($sformatf("u%0d_ready", k), k ? rdy1 : rdy0, er);
         if (k == sel) acc = vld & er;
         if (o < 0) own[k] = find(rr[k], -1);
         else if (ew) begin
            cnt[k]++;
            if (lst[o[1:0]] || (k == 1 && cnt[k] == 2)) begin
               rr[k]  = (o + 1) % 4;
               cnt[k] = 0;
               own[k] = find(rr[k], o);
            end
         end
      end
   endtask

   task automatic prod_step();
      for (int i = 0; i < 4; i++) begin
         if (acc[i]) rp[i]++;
         if (!vld[i] || acc[i]) vld[i] = (wp[i] != rp[i]) && (!rnd || $urandom_range(3) != 0);
         {lst[i], dat[i]} = (wp[i] != rp[i]) ? mem[i][rp[i] % 256] : 17'd0;
      end
      acc = '0;
   endtask

   task automatic push(input int i, input int n);
      for (int b = 0; b < n; b++) begin
         mem[i][wp[i] % 256] = {(b == n - 1), 4'(i), 12'(sq[i])};
         wp[i]++;
         sq[i]++;
      end
      prod_step();
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      if ((sel ? wr1 : wr0) && ln < 256) begin
         ld[ln] = sel ? wd1 : wd0;
         lc[ln] = cyc;
         ln++;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (!man) prod_step();
   endtask

   function automatic logic idle_all();
      for (int i = 0; i < 4; i++) if (wp[i] != rp[i]) return 1'b0;
      return vld == 4'b0 && own[sel] < 0;
   endfunction

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (!idle_all() && n < budget) begin
         cycle();
         n++;
      end
      chk("drain", idle_all(), 1'b1);
   endtask

   task automatic reset();
      rst = 1'b1;
      #1;
      chk("rst_grant0", g0, 0);
      chk("rst_grant1", g1, 0);
      chk("rst_wr_en", {wr1, wr0}, 0);
      chk("rst_busy", {b1, b0}, 0);
      chk("rst_ready", {rdy1, rdy0}, 0);
      for (int i = 0; i < 4; i++) begin
         wp[i] = 0; rp[i] = 0; sq[i] = 0; dat[i] = '0;
      end
      for (int k = 0; k < 2; k++) begin
         own[k] = -1; rr[k] = 0; cnt[k] = 0;
      end
      vld = '0; lst = '0; acc = '0; fifo_full = 1'b0; ln = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; sel = 0; rnd = 1'b0; man = 1'b1;
      rst = 1'b1; fifo_full = 1'b0; vld = '0; lst = '0; acc = '0;
      e2 = '{1, 1, 1, 0, 0};
      e4 = '{16'h3000, 16'h3001, 16'h0000, 16'h3002, 16'h3003, 16'h3004};
      //         v        l        f     grant    wr    data      ready    busy
      tbl[0]  = {4'b0101, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0};
      tbl[1]  = {4'b0101, 4'b1111, 1'b0, 4'b0001, 1'b1, 16'hD000, 4'b0001, 1'b1};
      tbl[2]  = {4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 16'hD002, 4'b0100, 1'b1};
      tbl[3]  = {4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0};
      tbl[4]  = {4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0};
      tbl[5]  = {4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 16'hD001, 4'b0000, 1'b1};
      tbl[6]  = {4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 16'hD001, 4'b0010, 1'b1};
      tbl[7]  = {4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 16'hD001, 4'b0010, 1'b1};
      tbl[8]  = {4'b0011, 4'b0010, 1'b0, 4'b0010, 1'b1, 16'hD001, 4'b0010, 1'b1};
      tbl[9]  = {4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 16'hD000, 4'b0001, 1'b1};
      tbl[10] = {4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0};
      reset();
      for (int i = 0; i < 4; i++) dat[i] = 16'hD000 + 16'(i);
      for (int t = 0; t < 11; t++) begin
         vld = tbl[t].v; lst = tbl[t].l; fifo_full = tbl[t].f;
         #1;
         chk($sformatf("tv%0d_grant", t), g0, tbl[t].g);
         chk($sformatf("tv%0d_wr_en", t), wr0, tbl[t].w);
         chk($sformatf("tv%0d_wr_data", t), wd0, tbl[t].d);
         chk($sformatf("tv%0d_ready", t), rdy0, tbl[t].r);
         chk($sformatf("tv%0d_busy", t), b0, tbl[t].b);
         cycle();
      end
      man = 1'b0;
      // 3-beat packet on req1 locks out an always-valid req0, handover without a bubble
      reset();
      push(1, 3);
      cycle();
      push(0, 2);
      drain(40);
      chk("t2_writes", ln, 5);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t2_owner%0d", k), ld[k][15:12], e2[k]);
         chk($sformatf("t2_cycle%0d", k), lc[k] - lc[0], k);
      end
      // FIFO full for two cycles in the middle of a packet
      reset();
      push(2, 4);
      repeat (3) cycle();
      fifo_full = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("t3_full_wr_en", wr0, 1'b0);
         chk("t3_full_ready", rdy0, 4'b0000);
         chk("t3_full_grant", g0, 4'b0100);
         cycle();
      end
      fifo_full = 1'b0;
      drain(20);
      chk("t3_writes", ln, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("t3_beat%0d", k), ld[k], {4'h2, 12'(k)});
      // MAXBURST=2 truncation of a 5-beat packet on req3, pointer wrapping 3 -> 0
      sel = 1;
      reset();
      push(3, 5);
      cycle();
      push(0, 1);
      drain(40);
      chk("t4_writes", ln, 6);
      for (int k = 0; k < 6; k++) chk($sformatf("t4_beat%0d", k), ld[k], e4[k]);
      // saturated single-beat traffic on every requester
      sel = 0;
      reset();
      for (int r = 0; r < 16; r++) for (int i = 0; i < 4; i++) push(i, 1);
      drain(120);
      chk("t5_writes", ln, 64);
      for (int k = 0; k < 64; k++) begin
         chk($sformatf("t5_owner%0d", k), ld[k][15:12], k % 4);
         chk($sformatf("t5_cycle%0d", k), lc[k] - lc[0], k);
      end
      // reset in the middle of a packet, then priority restarts at req0
      reset();
      push(2, 6);
      repeat (3) cycle();
      reset();
      for (int i = 3; i >= 0; i--) push(i, 1);
      cycle();
      #1;
      chk("t6_grant", g0, 4'b0001);
      drain(40);
      chk("t6_writes", ln, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("t6_owner%0d", k), ld[k][15:12], k);
      // random packets, gaps and backpressure
      for (int s = 0; s < 2; s++) begin
         sel = s;
         reset();
         rnd = 1'b1;
         for (int c = 0; c < 400; c++) begin
            int i;
            if ($urandom_range(2) == 0) begin
               i = int'($urandom_range(3));
               if (wp[i] - rp[i] < 200) push(i, int'($urandom_range(4, 1)));
            end
            fifo_full = $urandom_range(4) == 0;
            cycle();
         end
         fifo_full = 1'b0;
         rnd = 1'b0;
         drain(2000);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
